// File: rtl/row_frame_scanner.sv
// row_frame_scanner: 8x8 frame store fed by the game FSM, scanned out row by
// row to a multiplexed LED matrix with one blanking cycle between rows.
// Optional feature macro: ROW_BLINK_EN (blink the display in WIN/LOSE states).
module row_frame_scanner #(
   parameter int unsigned SCAN_DIV     = 2500,
   parameter int unsigned BLINK_FRAMES = 64
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] val,
   input  logic [2:0] rowIndex,
   input  logic       writeStrobe,
   input  logic       clrarray,
   input  logic [2:0] game_state,
   output logic [7:0] row_sel,
   output logic [7:0] col_data,
   output logic       frame_tick
);

   localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned ROWS  = 8;

   typedef enum logic {ST_BLANK, ST_SHOW} state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       scan_row_q, scan_row_d;
   logic             tick_q, tick_d;
   logic [7:0]       frame_q [ROWS];
   logic [7:0]       frame_d [ROWS];
   logic             blank_data_c;

   // Frame store update: clear wins over a same-cycle write.
   always_comb begin
      for (int r = 0; r < ROWS; r++) frame_d[r] = frame_q[r];
      if (clrarray) begin
         for (int r = 0; r < ROWS; r++) frame_d[r] = 8'h00;
      end else if (writeStrobe) begin
         frame_d[rowIndex] = val;
      end
   end

   // Scan FSM next state: one BLANK cycle, then SCAN_DIV cycles of SHOW per row.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      scan_row_d = scan_row_q;
      tick_d     = 1'b0;
      case (state_q)
         ST_BLANK: begin
            state_d = ST_SHOW;
            cnt_d   = '0;
         end
         ST_SHOW: begin
            if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
               state_d    = ST_BLANK;
               scan_row_d = scan_row_q + 3'd1;
               tick_d     = (scan_row_q == 3'd7);
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = ST_BLANK;
      endcase
   end

   // State and frame store registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_BLANK;
         cnt_q      <= '0;
         scan_row_q <= 3'd0;
         tick_q     <= 1'b0;
         for (int r = 0; r < ROWS; r++) frame_q[r] <= 8'h00;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         scan_row_q <= scan_row_d;
         tick_q     <= tick_d;
         for (int r = 0; r < ROWS; r++) frame_q[r] <= frame_d[r];
      end
   end

`ifdef ROW_BLINK_EN
   localparam int unsigned BF_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   logic [BF_W-1:0] bcnt_q, bcnt_d;
   logic            phase_q, phase_d;
   logic            end_game_c;

   assign end_game_c = (game_state == 3'b101) || (game_state == 3'b111);

   // Blink phase: toggles every BLINK_FRAMES frame ticks, held clear outside WIN/LOSE.
   always_comb begin
      bcnt_d  = bcnt_q;
      phase_d = phase_q;
      if (!end_game_c) begin
         bcnt_d  = '0;
         phase_d = 1'b0;
      end else if (tick_q) begin
         if (bcnt_q == BF_W'(BLINK_FRAMES - 1)) begin
            bcnt_d  = '0;
            phase_d = ~phase_q;
         end else begin
            bcnt_d = bcnt_q + BF_W'(1);
         end
      end
   end

   // Blink counter registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         bcnt_q  <= '0;
         phase_q <= 1'b0;
      end else begin
         bcnt_q  <= bcnt_d;
         phase_q <= phase_d;
      end
   end

   assign blank_data_c = end_game_c && phase_q;
`else
   localparam int unsigned UNUSED_BLINK_FRAMES = BLINK_FRAMES;
   logic unused_game_state;
   assign unused_game_state = ^game_state;
   assign blank_data_c      = 1'b0;
`endif

   // Matrix drive derived from registered scan state.
   assign row_sel    = (state_q == ST_SHOW) ? ~(8'd1 << scan_row_q) : 8'hFF;
   assign col_data   = (state_q == ST_SHOW && !blank_data_c) ? frame_q[scan_row_q] : 8'h00;
   assign frame_tick = tick_q;

endmodule

// File: tb/tb_row_frame_scanner.sv
// Randomized bench for row_frame_scanner against a cycle-count based model.
module tb_row_frame_scanner;

   localparam int unsigned SD  = 4;
   localparam int unsigned BF  = 2;
   localparam int          ROWP = SD + 1;
   localparam int          FRMP = 8 * (SD + 1);

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] val;
   logic [2:0] rowIndex;
   logic       writeStrobe;
   logic       clrarray;
   logic [2:0] game_state;
   logic [7:0] row_sel;
   logic [7:0] col_data;
   logic       frame_tick;

   int         checks = 0;
   int         errors = 0;
   int         t_m = 0;
   logic [7:0] mframe [8];
   logic [2:0] gs_cur;

   row_frame_scanner #(.SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
      .clk        (clk),
      .reset      (reset),
      .val        (val),
      .rowIndex   (rowIndex),
      .writeStrobe(writeStrobe),
      .clrarray   (clrarray),
      .game_state (game_state),
      .row_sel    (row_sel),
      .col_data   (col_data),
      .frame_tick (frame_tick)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h (t=%0d)", tag, got, exp, t_m);
      end
   endtask

   // One clock: drive inputs, advance the model at the edge, then check outputs.
   task automatic step(input logic rst, input logic ws, input logic clr,
                       input logic [2:0] ri, input logic [7:0] v, input logic [2:0] gs);
      int         pos, row, frm;
      logic [7:0] e_sel, e_col, e_tick;
      reset = rst; writeStrobe = ws; clrarray = clr; rowIndex = ri; val = v; game_state = gs;
      @(posedge clk);
      if (rst) begin
         t_m = 0;
         for (int r = 0; r < 8; r++) mframe[r] = 8'h00;
      end else begin
         t_m++;
         if (clr) for (int r = 0; r < 8; r++) mframe[r] = 8'h00;
         else if (ws) mframe[ri] = v;
      end
      #1;
      pos = t_m % ROWP;
      row = (t_m / ROWP) % 8;
      frm = t_m / FRMP;
      if (pos == 0) begin
         e_sel = 8'hFF;
         e_col = 8'h00;
      end else begin
         e_sel = ~(8'd1 << row);
         e_col = mframe[row];
`ifdef ROW_BLINK_EN
         if ((gs == 3'b101 || gs == 3'b111) && ((frm / BF) % 2 == 1)) e_col = 8'h00;
`endif
      end
      e_tick = (t_m > 0 && t_m % FRMP == 0) ? 8'd1 : 8'd0;
      check("row_sel", row_sel, e_sel);
      check("col_data", col_data, e_col);
      check("frame_tick", {7'd0, frame_tick}, e_tick);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, gs_cur);
   endtask

   initial begin
      gs_cur = 3'b001;
      // reset, then the plain scan pattern across two frames
      step(1'b1, 1'b0, 1'b0, 3'd0, 8'h00, gs_cur);
      step(1'b1, 1'b0, 1'b0, 3'd0, 8'h00, gs_cur);
      idle(2 * FRMP);
      // single row write visible only in its own row
      step(1'b0, 1'b1, 1'b0, 3'd3, 8'hE0, gs_cur);
      idle(FRMP);
      // clear beats a same-cycle write
      step(1'b0, 1'b1, 1'b1, 3'd2, 8'hFF, gs_cur);
      idle(FRMP);
      // write row 0 while row 0 is showing
      step(1'b1, 1'b0, 1'b0, 3'd0, 8'h00, gs_cur);
      idle(1);
      step(1'b0, 1'b1, 1'b0, 3'd0, 8'h1C, gs_cur);
      idle(FRMP);
      // fill all rows, then reset in the middle of row 5
      for (int r = 0; r < 8; r++) step(1'b0, 1'b1, 1'b0, 3'(r), 8'(8'h11 * (r + 1)), gs_cur);
      while (!(t_m % FRMP == 5 * ROWP + 2)) idle(1);
      step(1'b1, 1'b0, 1'b0, 3'd0, 8'h00, gs_cur);
      idle(FRMP);
      // end-game state over several frames, then a normal state
      for (int g = 0; g < 2; g++) begin
         gs_cur = (g == 0) ? 3'b101 : 3'b001;
         step(1'b1, 1'b0, 1'b0, 3'd0, 8'h00, gs_cur);
         for (int r = 0; r < 8; r++) step(1'b0, 1'b1, 1'b0, 3'(r), 8'hA5 ^ 8'(r), gs_cur);
         idle(5 * FRMP);
      end
      // random traffic; game_state only changes together with reset
      for (int i = 0; i < 4000; i++) begin
         logic rst;
         rst = ($urandom_range(0, 299) == 0);
         if (rst) begin
            case ($urandom_range(0, 3))
               0: gs_cur = 3'b101;
               1: gs_cur = 3'b111;
               2: gs_cur = 3'b001;
               default: gs_cur = 3'b011;
            endcase
         end
         step(rst, ($urandom_range(0, 3) == 0), ($urandom_range(0, 63) == 0),
              3'($urandom), 8'($urandom), gs_cur);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/row_frame_scanner.md
# row_frame_scanner

Downstream consumer of the stacker game FSM. Captures each `val`/`rowIndex` row write into an 8x8 frame store and clears it on `clrarray`. Continuously scans the store out to a row-multiplexed 8x8 LED matrix, one row at a time, with a blanking cycle between rows. Sits between the game FSM and the board's matrix drivers.

## Interface
Parameters:
- `SCAN_DIV`, 2500: clock cycles each row is shown; legal range ≥ 1.
- `BLINK_FRAMES`, 64: full frames per blink half-period; legal range ≥ 1. Used only with `ROW_BLINK_EN`.

Ports:
- `clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `val`  in  8  row pattern from the FSM; bit 7 = leftmost column.
- `rowIndex`  in  3  target row of the write.
- `writeStrobe`  in  1  write `val` into `frame[rowIndex]` this cycle.
- `clrarray`  in  1  clear the entire frame store this cycle.
- `game_state`  in  3  FSM state. WIN = 3'b101, LOSE = 3'b111.
- `row_sel`  out  8  active-low row enable; bit r drives physical row r.
- `col_data`  out  8  active-high column data for the selected row.
- `frame_tick`  out  1  one-cycle pulse when the scan wraps from row 7 to row 0.

## Operation
**Frame store**
- Eight 8-bit registers, `frame[0..7]`.
- When `clrarray` = 1, all eight rows are set to 0 in one cycle. `clrarray` has priority over `writeStrobe` in the same cycle.
- When `writeStrobe` = 1 and `clrarray` = 0, `frame[rowIndex]` is loaded with `val`. All other rows hold.
- Repeated strobes to the same row: the last one wins. There is no read-modify-write.

**Scan FSM** (two states)
- BLANK: lasts 1 cycle. `row_sel` = 8'hFF, `col_data` = 8'h00. Transitions to SHOW.
- SHOW: lasts exactly `SCAN_DIV` cycles.
  - `row_sel` = ~(8'b1 << scan_row) and `col_data` = `frame[scan_row]`. Both are combinational from registered state, so a store write is visible the cycle after the strobe.
  - On the last cycle, `scan_row` increments and wraps 7→0, then the FSM goes to BLANK.
- The cycle counter resets to 0 on entry to SHOW. Its width is the clog2 of `SCAN_DIV`, minimum 1 bit.
- `frame_tick` is registered. It is high in the first BLANK cycle after `scan_row` wraps 7→0.

**Reset**
- Frame store = 0, `scan_row` = 0, FSM = BLANK, counter = 0, blink state = 0.
- The outputs therefore read `row_sel` = 8'hFF, `col_data` = 0, `frame_tick` = 0 in the cycle after reset.
- Reset asserted mid-row aborts the scan immediately. No partial state survives.

## Timing
- Row period = `SCAN_DIV` + 1 cycles. Frame period = 8·(`SCAN_DIV` + 1) cycles.
- First SHOW of row 0 begins 1 cycle after reset deasserts.
- Write latency: store updated at the strobe edge. Seen on `col_data` in the next cycle if that row is in SHOW; otherwise at its next SHOW.
- Writes and clears are accepted in every scan state, with no stall and no handshake. Input is never dropped.
- Inputs arrive from the same `clk` domain; there is no synchronizer.

## Configuration
- Macro `ROW_BLINK_EN` defined:
  - A frame counter advances on each `frame_tick`. A blink phase bit toggles every `BLINK_FRAMES` ticks.
  - While `game_state` is WIN or LOSE and the phase bit is 1, `col_data` is forced to 0 during SHOW. `row_sel` is unchanged.
  - When `game_state` leaves WIN/LOSE, the counter and phase are cleared in the same cycle.
- Macro `ROW_BLINK_EN` undefined:
  - No blink logic is built and `game_state` is ignored.
  - `col_data` always equals `frame[scan_row]` in SHOW.

## Test plan
- Reset, `SCAN_DIV`=4 → `row_sel` = FF for 1 cycle, then FE for 4 cycles, FF for 1, FD for 4, …; `frame_tick` pulses every 40 cycles.
- Write `rowIndex`=3, `val`=8'hE0 → in row 3's SHOW, `row_sel` = F7 and `col_data` = E0; all other rows show 00.
- Same-cycle `writeStrobe` (row 2, 8'hFF) and `clrarray` → all rows read 00.
- Write 8'h1C to row 0 while row 0 is in SHOW → `col_data` = 1C from the next cycle.
- Assert `reset` mid-SHOW of row 5 after filling rows → next cycle `row_sel` = FF and all rows read 00; scan restarts at row 0.
- `ROW_BLINK_EN`, `BLINK_FRAMES`=2, `game_state`=3'b101 → `col_data` alternates between frame data and 00 every 2 frames; with `game_state`=3'b001, data shown continuously.
